mem_bus_arbiter: RTL

- Shares the single MAR/MDR/memory path between three memory-using controllers: 0 = instruction fetch, 1 = load, 2 = store.
- Grants the path to one requester at a time using round-robin priority.
- Sequences the full read or write transaction itself: MAR load, memory enable, wait for MFC, then MDR transfer.
- Requesters drive only the internal bus (address/data) while granted. This block owns every MAR/MDR/MEM strobe.

---
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single MAR/MDR/memory path between three memory-using
// controllers (0 = instruction fetch, 1 = load, 2 = store). A round-robin
// arbiter in IDLE picks one requester. A Moore sequencer then runs the whole
// read or write transaction: MAR load, memory enable, wait for MFC, and the
// MDR transfer. Requesters only drive the internal bus while they hold grant;
// this block owns every MAR/MDR/MEM strobe.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   req[2:0]       per-requester level request
//   rw[2:0]        per-requester direction (1 = read), sampled at grant
//   MFC            memory function complete, active low
//   grant[2:0]     one-hot path owner, held from ADDR through FIN
//   MAR_write      MAR loads address from bus
//   MAR_mem_read   memory takes address from MAR
//   MEM_EN         memory enable
//   MEM_RW         1 = memory read, 0 = memory write
//   MDR_write      MDR loads write data from bus
//   MDR_mem_read   memory takes write data from MDR
//   MDR_mem_write  MDR captures memory read data
//   MDR_read       MDR drives bus to the requester
//   done[2:0]      one-cycle pulse to the owner at end of transaction
//   err            one-cycle pulse with done when the access timed out
//   busy           high in every state except IDLE
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] rw,
    input  logic       MFC,
    output logic [2:0] grant,
    output logic       MAR_write,
    output logic       MAR_mem_read,
    output logic       MEM_EN,
    output logic       MEM_RW,
    output logic       MDR_write,
    output logic       MDR_mem_read,
    output logic       MDR_mem_write,
    output logic       MDR_read,
    output logic [2:0] done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_XFER,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [1:0]         last_q,  last_d;
    logic               dir_q,   dir_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Round-robin pick: first set req bit searching last+1, last+2, last.
    logic               pick_found;
    logic [1:0]         pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            int cand;
            cand = (int'(last_q) + k) % 3;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = 2'(cand);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            last_q  <= 2'd2;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default at the top of the block so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        dir_d   = dir_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                grant_d = 3'b000;
                err_d   = 1'b0;
                if (pick_found) begin
                    grant_d = 3'b001 << pick_idx;
                    last_d  = pick_idx;
                    dir_d   = rw[pick_idx];
                    state_d = S_ADDR;
                end
            end
            S_ADDR:  state_d = dir_q ? S_ISSUE : S_DATA;
            S_DATA:  state_d = S_ISSUE;
            S_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!MFC) begin
                    state_d = dir_q ? S_CAPT : S_FIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Timed-out reads skip CAPT/XFER entirely.
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_CAPT:  state_d = S_XFER;
            S_XFER:  state_d = S_FIN;
            S_FIN: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from state and the registered grant, so an
    // asynchronous reset drops every output immediately.
    always_comb begin
        grant         = grant_q;
        MAR_write     = 1'b0;
        MAR_mem_read  = 1'b0;
        MEM_EN        = 1'b0;
        MEM_RW        = 1'b0;
        MDR_write     = 1'b0;
        MDR_mem_read  = 1'b0;
        MDR_mem_write = 1'b0;
        MDR_read      = 1'b0;
        done          = 3'b000;
        err           = 1'b0;
        busy          = (state_q != S_IDLE);

        unique case (state_q)
            S_ADDR:  MAR_write = 1'b1;
            S_DATA:  MDR_write = 1'b1;
            S_ISSUE: begin
                MAR_mem_read = 1'b1;
                MEM_EN       = 1'b1;
                MEM_RW       = dir_q;
                MDR_mem_read = ~dir_q;
            end
            S_CAPT:  MDR_mem_write = 1'b1;
            S_XFER:  MDR_read      = 1'b1;
            S_FIN: begin
                done = grant_q;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
